aimc_ui_initiator: RTL and testbench
====================================

Name: aimc_ui_initiator

Overview:
- Traffic initiator that drives the AIMC user-interface request channel (request valid/ready) and consumes the response channel (response valid, no backpressure).
- Issues a programmed burst of writes and/or reads with address-derived data, tracks outstanding reads by tag, and checks returned data.
- Used for bring-up and post-calibration self-test in the same clk_div domain as the controller.

Parameters:
ADDR_W, 28, request address width
DATA_W, 256, payload width; multiple of 32
TAG_W, 4, read tag width; outstanding table has 2**TAG_W entries
CNT_W, 16, request-count width
TIMEOUT_CYC, 4096, drain timeout in clk_div cycles

Ports:
clk_div  in  1  clock
rst_div  in  1  reset, asynchronous, active-high
start  in  1  one-cycle pulse; ignored unless idle
mode  in  2  0=write-only, 1=read-only, 2=write-then-read, 3=reserved (treated as 0)
num_req  in  CNT_W  requests per phase; 0 means go straight to DONE
base_addr  in  ADDR_W  first address
stride  in  ADDR_W  address increment per request
seed  in  32  data pattern seed
ui_pkt_valid  out  1  request valid
ui_req_we  out  1  1=write, 0=read
ui_req_addr  out  ADDR_W  request address
ui_req_data  out  DATA_W  write data (0 on reads)
ui_req_tag  out  TAG_W  read tag (0 on writes)
aimc_rdy  in  1  controller ready
aimc_pkt_valid  in  1  read response valid
aimc_rsp_tag  in  TAG_W  response tag
aimc_rsp_data  in  DATA_W  response data
busy  out  1  not idle
done  out  1  one-cycle pulse at completion
err_cnt  out  CNT_W  mismatched or unexpected responses, saturating
timeout  out  1  sticky; set if drain times out, cleared by start
outstanding  out  TAG_W+1  reads in flight

Behaviour:
- Reset: all outputs 0, FSM in IDLE, tag table cleared.
- Data pattern: 32-bit lane i = addr[31:0] zero-extended ^ seed ^ (i * 32'h9E3779B9), truncated mod 2^32.
- Handshake: a transfer occurs when ui_pkt_valid && aimc_rdy. Once valid is asserted, it is held with a stable payload until accepted. Valid is asserted the cycle after entering an issuing state, then back-to-back with no bubble while aimc_rdy is high.
- Address: starts at base_addr and advances by stride on each accepted request, wrapping mod 2^ADDR_W. The counter reloads to base_addr at the start of the read phase.
- FSM states:
  - IDLE: on start, go to WR if mode is 0, 2 or 3; go to RD if mode is 1.
  - WR: after num_req accepted writes, go to RD if mode is 2, otherwise DONE.
  - RD: issues reads only while outstanding < 2**TAG_W; valid drops while the table is full. Tags are allocated sequentially mod 2**TAG_W. After num_req accepted reads, go to DRAIN.
  - DRAIN: go to DONE when outstanding == 0, or when TIMEOUT_CYC cycles pass with no response (sets timeout).
  - DONE: pulses done for one cycle, then returns to IDLE.
- Tag table: each entry holds a valid bit and the expected address.
  - On accept, set valid for that tag.
  - On a response with a valid tag: compare data to the pattern of the stored address, increment err_cnt on mismatch, clear the valid bit.
  - A response with an invalid tag, or in IDLE/WR, increments err_cnt and leaves the table unchanged.
- Simultaneous accept and response in the same cycle: outstanding stays unchanged. If both hit the same tag, the response clears first and the accept sets; this is only legal when the table was full, which is blocked, so it cannot occur.
- start clears err_cnt and timeout. start while busy is ignored.
- Reset mid-operation: returns to IDLE immediately and clears the table; responses that arrive later are counted as errors only if the block has been started again.

Optional Feature:
- Macro AIMC_UI_INIT_ERR_INJ_EN.
- When defined: adds input err_inj (1 bit). A pulse arms injection; the next accepted write has data bit 0 inverted, then the arm is cleared. A later read of that address must raise err_cnt by 1.
- When undefined: no port, no logic, data is always the pure pattern.

Test Plan:
- mode=2, num_req=8, base=0x100, stride=0x20, aimc_rdy=1, responder echoes stored data in order -> 8 writes then 8 reads at addresses 0x100..0x1E0; done pulses; err_cnt=0; outstanding returns to 0.
- mode=1, num_req=20, TAG_W=4, responder holds all responses -> exactly 16 reads issued, then ui_pkt_valid=0 while outstanding=16; releasing responses out of order completes all 20 with err_cnt=0.
- aimc_rdy toggled pseudo-randomly during WR -> payload stable while valid && !rdy; no lost or duplicated addresses.
- Responder corrupts lane 3 of 2 responses and sends 1 response with an unused tag -> err_cnt=3.
- mode=1, num_req=4, responder drops 1 response -> timeout=1 after 4096 idle cycles, done pulses, outstanding=1. A new start clears timeout and err_cnt.
- rst_div asserted in RD with 5 outstanding -> all outputs 0 next edge; base_addr=0xFFFFFE0, stride=0x20 wraps to 0x0000000 on the second request.

Source files
------------

// File: rtl/aimc_ui_initiator.sv
// aimc_ui_initiator: AIMC UI traffic initiator with read-data checking; optional AIMC_UI_INIT_ERR_INJ_EN adds err_inj
module aimc_ui_initiator #(
  parameter int ADDR_W      = 28,
  parameter int DATA_W      = 256,
  parameter int TAG_W       = 4,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic              clk_div,
  input  logic              rst_div,
`ifdef AIMC_UI_INIT_ERR_INJ_EN
  input  logic              err_inj,
`endif
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [CNT_W-1:0]  num_req,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] stride,
  input  logic [31:0]       seed,
  output logic              ui_pkt_valid,
  output logic              ui_req_we,
  output logic [ADDR_W-1:0] ui_req_addr,
  output logic [DATA_W-1:0] ui_req_data,
  output logic [TAG_W-1:0]  ui_req_tag,
  input  logic              aimc_rdy,
  input  logic              aimc_pkt_valid,
  input  logic [TAG_W-1:0]  aimc_rsp_tag,
  input  logic [DATA_W-1:0] aimc_rsp_data,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              timeout,
  output logic [TAG_W:0]    outstanding
);
  localparam int LANES = DATA_W / 32;
  localparam int DEPTH = 2 ** TAG_W;
  localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {IDLE, WR, RD, DRAIN, DONE} state_t;

  state_t            state, state_nx;
  logic [1:0]        mode_q;
  logic [CNT_W-1:0]  num_q, cnt;
  logic [ADDR_W-1:0] stride_q, base_q, addr_q;
  logic [31:0]       seed_q;
  logic [TAG_W-1:0]  tag_q;
  logic [DEPTH-1:0]  tv;
  logic [ADDR_W-1:0] ta [DEPTH];
  logic [TO_W-1:0]   idle_cnt;
  logic              entered, started, inj_bit;
  logic              kick, acc, acc_rd, last, tag_hit, mismatch, err_ev, to_fire;

  function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a, input logic [31:0] s);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++) r[i*32 +: 32] = 32'(a) ^ s ^ (32'(i) * 32'h9E3779B9);
    return r;
  endfunction

  // Valid is withheld on the first cycle of a phase; reads also wait for the next tag slot to be free.
  assign kick         = state == IDLE && start;
  assign ui_pkt_valid = !entered && (state == WR || (state == RD && !tv[tag_q]));
  assign ui_req_we    = state == WR;
  assign ui_req_addr  = addr_q;
  assign ui_req_data  = state == WR ? pat(addr_q, seed_q) ^ DATA_W'(inj_bit) : '0;
  assign ui_req_tag   = state == RD ? tag_q : '0;
  assign busy         = state != IDLE;
  assign done         = state == DONE;
  assign acc          = ui_pkt_valid && aimc_rdy;
  assign acc_rd       = acc && state == RD;
  assign last         = cnt == num_q - 1'b1;
  assign tag_hit      = aimc_pkt_valid && (state == RD || state == DRAIN || state == DONE) && tv[aimc_rsp_tag];
  assign mismatch     = aimc_rsp_data != pat(ta[aimc_rsp_tag], seed_q);
  assign err_ev       = aimc_pkt_valid && started && (!tag_hit || mismatch);
  assign to_fire      = state == DRAIN && !aimc_pkt_valid && idle_cnt == TO_W'(TIMEOUT_CYC - 1) && outstanding != '0;

  // Phase sequencing: write phase, read phase, drain, one-cycle done.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = num_req == '0 ? DONE : (mode == 2'd1 ? RD : WR);
      WR:      if (acc && last) state_nx = mode_q == 2'd2 ? RD : DONE;
      RD:      if (acc && last) state_nx = DRAIN;
      DRAIN:   if (outstanding == '0 || to_fire) state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  // State, latched run configuration, address/tag/request counters and drain idle timer.
  always_ff @(posedge clk_div or posedge rst_div) begin
    if (rst_div) begin
      state    <= IDLE;
      entered  <= 1'b0;
      started  <= 1'b0;
      mode_q   <= '0;
      num_q    <= '0;
      base_q   <= '0;
      stride_q <= '0;
      seed_q   <= '0;
      addr_q   <= '0;
      cnt      <= '0;
      tag_q    <= '0;
      idle_cnt <= '0;
    end else begin
      state    <= state_nx;
      entered  <= state_nx != state;
      idle_cnt <= (state == DRAIN && !aimc_pkt_valid) ? idle_cnt + 1'b1 : '0;
      if (kick) begin
        started  <= 1'b1;
        mode_q   <= mode;
        num_q    <= num_req;
        base_q   <= base_addr;
        stride_q <= stride;
        seed_q   <= seed;
        addr_q   <= base_addr;
        cnt      <= '0;
        tag_q    <= '0;
      end else if (state == WR && state_nx == RD) begin
        addr_q <= base_q;
        cnt    <= '0;
      end else if (acc) begin
        addr_q <= addr_q + stride_q;
        cnt    <= cnt + 1'b1;
        tag_q  <= acc_rd ? tag_q + 1'b1 : tag_q;
      end
    end
  end

  // Error counter (saturating) and sticky drain timeout, both cleared by an accepted start.
  always_ff @(posedge clk_div or posedge rst_div) begin
    if (rst_div) begin
      err_cnt <= '0;
      timeout <= 1'b0;
    end else if (kick) begin
      err_cnt <= '0;
      timeout <= 1'b0;
    end else begin
      err_cnt <= (err_ev && err_cnt != '1) ? err_cnt + 1'b1 : err_cnt;
      timeout <= timeout | to_fire;
    end
  end

  // Outstanding-read table: response clears its entry before an accept sets one.
  always_ff @(posedge clk_div or posedge rst_div) begin
    if (rst_div) begin
      tv          <= '0;
      outstanding <= '0;
    end else if (kick) begin
      tv          <= '0;
      outstanding <= '0;
    end else begin
      if (tag_hit) tv[aimc_rsp_tag] <= 1'b0;
      if (acc_rd) tv[tag_q] <= 1'b1;
      outstanding <= outstanding + {{TAG_W{1'b0}}, acc_rd} - {{TAG_W{1'b0}}, tag_hit};
    end
  end

  // Expected address per tag, captured when the read is accepted.
  always_ff @(posedge clk_div) begin
    if (acc_rd) ta[tag_q] <= addr_q;
  end

`ifdef AIMC_UI_INIT_ERR_INJ_EN
  logic inj_arm;
  // Injection arm: set by err_inj, consumed by the next accepted write.
  always_ff @(posedge clk_div or posedge rst_div) begin
    if (rst_div) inj_arm <= 1'b0;
    else if (acc && state == WR && inj_arm) inj_arm <= 1'b0;
    else if (err_inj) inj_arm <= 1'b1;
  end
  assign inj_bit = inj_arm;
`else
  assign inj_bit = 1'b0;
`endif
endmodule

// File: tb/tb_aimc_ui_initiator.sv
// tb_aimc_ui_initiator: scoreboard bench for aimc_ui_initiator
module tb_aimc_ui_initiator;
  typedef struct packed {
    logic         we;
    logic [27:0]  addr;
    logic [255:0] data;
    logic [3:0]   tag;
  } req_t;

  logic         clk_div = 1'b0, rst_div = 1'b1, start = 1'b0;
  logic [1:0]   mode = '0;
  logic [15:0]  num_req = '0;
  logic [27:0]  base_addr = '0, stride = '0;
  logic [31:0]  seed = '0;
  logic         ui_pkt_valid, ui_req_we, aimc_rdy = 1'b1, aimc_pkt_valid = 1'b0;
  logic [27:0]  ui_req_addr;
  logic [255:0] ui_req_data, aimc_rsp_data = '0;
  logic [3:0]   ui_req_tag, aimc_rsp_tag = '0;
  logic         busy, done, timeout;
  logic [15:0]  err_cnt;
  logic [4:0]   outstanding;
`ifdef AIMC_UI_INIT_ERR_INJ_EN
  logic         err_inj = 1'b0;
`endif

  aimc_ui_initiator dut (
    .clk_div(clk_div), .rst_div(rst_div),
`ifdef AIMC_UI_INIT_ERR_INJ_EN
    .err_inj(err_inj),
`endif
    .start(start), .mode(mode), .num_req(num_req), .base_addr(base_addr), .stride(stride), .seed(seed),
    .ui_pkt_valid(ui_pkt_valid), .ui_req_we(ui_req_we), .ui_req_addr(ui_req_addr), .ui_req_data(ui_req_data),
    .ui_req_tag(ui_req_tag), .aimc_rdy(aimc_rdy), .aimc_pkt_valid(aimc_pkt_valid), .aimc_rsp_tag(aimc_rsp_tag),
    .aimc_rsp_data(aimc_rsp_data), .busy(busy), .done(done), .err_cnt(err_cnt), .timeout(timeout),
    .outstanding(outstanding)
  );

  always #5 clk_div = ~clk_div;

  int           checks = 0, errors = 0, done_seen = 0, tag_ctr = 0, used;
  req_t         exp_q[$];
  logic [3:0]   pend_tag[$];
  logic [27:0]  pend_addr[$];
  logic [255:0] mem [logic [27:0]];
  logic         stall_q = 1'b0;
  req_t         hold;

  function automatic logic [255:0] pat(input logic [27:0] a, input logic [31:0] s);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = {4'h0, a} ^ s ^ (32'(i) * 32'h9E3779B9);
    return r;
  endfunction

  task automatic chk(input string name, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_div);
    #1;
  endtask

  task automatic push_exp(input logic we, input int n, input logic [27:0] base, input logic [27:0] str);
    logic [27:0] a;
    a = base;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{we, a, we ? pat(a, seed) : 256'h0, we ? 4'h0 : 4'(tag_ctr)});
      if (!we) tag_ctr++;
      a = a + str;
    end
  endtask

  task automatic go(input logic [1:0] m, input int n, input logic [27:0] b, input logic [27:0] s, input logic [31:0] sd);
    mode = m; num_req = 16'(n); base_addr = b; stride = s; seed = sd; tag_ctr = 0;
    mem.delete();
    if (n > 0) begin
      if (m != 2'd1) push_exp(1'b1, n, b, s);
      if (m == 2'd1 || m == 2'd2) push_exp(1'b0, n, b, s);
    end
    step(); start = 1'b1;
    step(); start = 1'b0;
  endtask

  task automatic send(input logic [3:0] t, input logic [255:0] d);
    step();
    aimc_pkt_valid = 1'b1; aimc_rsp_tag = t; aimc_rsp_data = d;
  endtask

  task automatic run(input int max, input bit rnd, input bit respond, input bit shuffle, input int keep,
                     input bit need_done, output int n);
    int k;
    done_seen = 0; n = 0;
    while (n < max && done_seen == 0) begin
      step(); n++;
      aimc_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      aimc_pkt_valid = 1'b0;
      if (respond && pend_tag.size() > keep) begin
        k = shuffle ? $urandom_range(0, pend_tag.size() - 1) : 0;
        aimc_pkt_valid = 1'b1; aimc_rsp_tag = pend_tag[k];
        aimc_rsp_data = mem.exists(pend_addr[k]) ? mem[pend_addr[k]] : pat(pend_addr[k], seed);
        pend_tag.delete(k); pend_addr.delete(k);
      end
    end
    step();
    aimc_pkt_valid = 1'b0; aimc_rdy = 1'b1;
    if (need_done) chk("done_reached", 1'(done_seen != 0), 1'b1);
  endtask

  // Request monitor: stability while stalled, scoreboard compare on every accept.
  always @(negedge clk_div) begin
    req_t e;
    if (done) done_seen++;
    if (stall_q) begin
      chk("hold_valid", ui_pkt_valid, 1'b1);
      chk("hold_addr", ui_req_addr, hold.addr);
      chk("hold_data", ui_req_data, hold.data);
    end
    stall_q = ui_pkt_valid && !aimc_rdy;
    hold = '{ui_req_we, ui_req_addr, ui_req_data, ui_req_tag};
    if (ui_pkt_valid && aimc_rdy) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL extra_req observed addr=%0h expected no request", ui_req_addr);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("req_we", ui_req_we, e.we);
        chk("req_addr", ui_req_addr, e.addr);
        chk("req_data", ui_req_data, e.data);
        chk("req_tag", ui_req_tag, e.tag);
      end
      if (ui_req_we) mem[ui_req_addr] = ui_req_data;
      else begin
        pend_tag.push_back(ui_req_tag);
        pend_addr.push_back(ui_req_addr);
      end
    end
  end

  initial begin
    repeat (3) step();
    chk("rst_valid", ui_pkt_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err_cnt, 16'd0);
    chk("rst_outst", outstanding, 5'd0);
    chk("rst_addr", ui_req_addr, 28'd0);
    rst_div = 1'b0;
    step();

    // write-then-read, in-order echo
    go(2'd2, 8, 28'h100, 28'h20, 32'h1234_5678);
    run(200, 1'b0, 1'b1, 1'b0, 0, 1'b1, used);
    chk("t1_err", err_cnt, 16'd0);
    chk("t1_outst", outstanding, 5'd0);
    chk("t1_drained", 32'(exp_q.size()), 32'd0);
    chk("t1_done_once", 32'(done_seen), 32'd1);
    chk("t1_idle", busy, 1'b0);

    // read-only beyond table depth, held then released out of order
    go(2'd1, 20, 28'h2000, 28'h40, 32'hCAFE_F00D);
    run(40, 1'b0, 1'b0, 1'b0, 0, 1'b0, used);
    chk("t2_outst_full", outstanding, 5'd16);
    chk("t2_valid_low", ui_pkt_valid, 1'b0);
    chk("t2_issued", 32'(pend_tag.size()), 32'd16);
    run(400, 1'b0, 1'b1, 1'b1, 0, 1'b1, used);
    chk("t2_err", err_cnt, 16'd0);
    chk("t2_outst", outstanding, 5'd0);
    chk("t2_drained", 32'(exp_q.size()), 32'd0);

    // write-only with random ready backpressure
    go(2'd0, 12, 28'h40, 28'h40, 32'h0BAD_BEEF);
    run(400, 1'b1, 1'b0, 1'b0, 0, 1'b1, used);
    chk("t3_drained", 32'(exp_q.size()), 32'd0);
    chk("t3_err", err_cnt, 16'd0);

    // two lane-3 corruptions plus one unknown tag
    go(2'd1, 6, 28'h300, 28'h10, 32'h5555_AAAA);
    run(30, 1'b0, 1'b0, 1'b0, 0, 1'b0, used);
    chk("t4_issued", 32'(pend_tag.size()), 32'd6);
    send(4'd12, 256'h0);
    for (int k = 0; k < 6; k++) send(pend_tag[k], pat(pend_addr[k], seed) ^ (k < 2 ? 256'h1 << 96 : 256'h0));
    pend_tag.delete(); pend_addr.delete();
    run(20, 1'b0, 1'b0, 1'b0, 0, 1'b1, used);
    chk("t4_err", err_cnt, 16'd3);
    chk("t4_outst", outstanding, 5'd0);

    // dropped response -> drain timeout
    go(2'd1, 4, 28'h400, 28'h20, 32'h0);
    run(5000, 1'b0, 1'b1, 1'b0, 1, 1'b1, used);
    chk("t5_timeout", timeout, 1'b1);
    chk("t5_outst", outstanding, 5'd1);
    chk("t5_err", err_cnt, 16'd0);
    chk("t5_wait_len", 1'(used >= 4096), 1'b1);
    pend_tag.delete(); pend_addr.delete();
    send(4'd9, 256'h0);
    step(); aimc_pkt_valid = 1'b0;
    chk("t5_late_rsp_err", err_cnt, 16'd1);
    go(2'd0, 0, 28'h0, 28'h0, 32'h0);
    run(10, 1'b0, 1'b0, 1'b0, 0, 1'b1, used);
    chk("t5_clr_timeout", timeout, 1'b0);
    chk("t5_clr_err", err_cnt, 16'd0);

    // reset mid read phase with address wrap
    go(2'd1, 8, 28'hFFFFFE0, 28'h20, 32'h7777_0000);
    for (int c = 0; c < 30 && pend_tag.size() < 5; c++) step();
    chk("t6_outst", outstanding, 5'd5);
    chk("t6_wrap_addr", pend_addr[1], 28'h0);
    rst_div = 1'b1;
    #1;
    chk("t6_rst_valid", ui_pkt_valid, 1'b0);
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_outst", outstanding, 5'd0);
    chk("t6_rst_addr", ui_req_addr, 28'h0);
    chk("t6_rst_tag", ui_req_tag, 4'h0);
    exp_q.delete(); pend_tag.delete(); pend_addr.delete();
    step(); rst_div = 1'b0;
    send(4'd2, 256'h0);
    step(); aimc_pkt_valid = 1'b0;
    step();
    chk("t6_post_rst_err", err_cnt, 16'd0);
    chk("t6_post_rst_idle", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
